// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point accumulate controller.
// Holds the controller FSM state type and the IEEE-754 single constants
// the controller and its environment agree on.
package fp_pkg;

  localparam int FP_W = 32;

  localparam logic [FP_W-1:0] FP_ZERO        = 32'h0000_0000;
  // Value the external add/sub unit returns when it flags an exception.
  localparam logic [FP_W-1:0] FP_EXC_PATTERN = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fp_accum_ctrl.sv
// Floating-point accumulate controller.
//
// Sums a stream of IEEE-754 single operands using an external combinational
// add/sub unit. Each accepted beat folds (acc +/- in_data) back into the
// accumulator on the same edge, so one beat per cycle is sustained. The beat
// carrying in_last closes the sum; the result is offered on the out_* port
// until the consumer takes it, after which the block returns to IDLE.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        operand beat handshake
//   in_data, in_sub, in_last operand, add(0)/sub(1) select, end-of-sum marker
//   au_a, au_b, au_sign      operands/select driven to the add/sub unit
//   au_result, au_exception  combinational result/exception from the unit
//   out_valid/out_ready      result handshake
//   out_sum, out_exception, out_count  final sum, sticky exception, beat count
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1. in_ready never depends on in_valid; out_valid never depends on
// out_ready, and the out_* payload holds while out_valid=1 and out_ready=0.
module fp_accum_ctrl
  import fp_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic [FP_W-1:0]  au_a,
  output logic [FP_W-1:0]  au_b,
  output logic             au_sign,
  input  logic [FP_W-1:0]  au_result,
  input  logic             au_exception,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_sum,
  output logic             out_exception,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_next;
  logic [FP_W-1:0]  acc;
  logic             exc_sticky;
  logic [CNT_W-1:0] count;
  logic             beat_acc;
  logic             out_hs;

  // The accumulator is only ever nonzero while a sum is open or waiting to
  // be consumed, so the unit sees 0 +/- in_data on the first beat of a sum.
  assign au_a    = acc;
  assign au_b    = in_data;
  assign au_sign = in_sub;

  // The registers already hold the final values while in DONE and cannot
  // change there (no beat is accepted), so they drive the outputs directly.
  assign out_sum       = acc;
  assign out_exception = exc_sticky;
  assign out_count     = count;

  always_comb begin
    state_next = state;
    // rst gates in_ready so it is low for the whole reset pulse, not just
    // after the state register has been forced.
    in_ready   = (state != ST_DONE) && !rst;
    out_valid  = (state == ST_DONE);
    beat_acc   = in_valid && in_ready;
    out_hs     = out_valid && out_ready;

    case (state)
      ST_IDLE, ST_ACCUM: begin
        if (beat_acc) begin
          state_next = in_last ? ST_DONE : ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (out_hs) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      acc        <= FP_ZERO;
      exc_sticky <= 1'b0;
      count      <= '0;
    end else begin
      state <= state_next;
      if (out_hs) begin
        acc        <= FP_ZERO;
        exc_sticky <= 1'b0;
        count      <= '0;
      end else if (beat_acc) begin
        // The unit's exception pattern is stored like any other result.
        acc        <= au_result;
        exc_sticky <= exc_sticky | au_exception;
        if (count != CNT_MAX) begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// Self-checking bench for fp_accum_ctrl. The bench plays the parent: it
// models the combinational add/sub unit for integer-valued singles and
// checks directed vectors, hand sequences and random sums against a
// reference computed with plain integer arithmetic.
module tb_fp_accum_ctrl;
  import fp_pkg::*;

  localparam int CNT_W   = 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_sub;
  logic             in_last;
  logic [31:0]      au_a;
  logic [31:0]      au_b;
  logic             au_sign;
  logic [31:0]      au_result;
  logic             au_exception;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_sum;
  logic             out_exception;
  logic [CNT_W-1:0] out_count;

  int n_cmp = 0;
  int n_bad = 0;

  fp_accum_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sub(in_sub), .in_last(in_last),
    .au_a(au_a), .au_b(au_b), .au_sign(au_sign),
    .au_result(au_result), .au_exception(au_exception),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_exception(out_exception), .out_count(out_count)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1, "bench watchdog expired");
  end

  // ---------------- integer <-> single helpers ----------------
  function automatic logic [31:0] int_to_sp(input int v);
    logic [31:0] a;
    logic [31:0] r;
    int p;
    if (v == 0) return 32'h0;
    a = (v < 0) ? 32'(-v) : 32'(v);
    p = 0;
    for (int i = 0; i < 32; i++) if (a[i]) p = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'(a << (23 - p));
    return r;
  endfunction

  function automatic int sp_to_int(input logic [31:0] x);
    int e;
    int mag;
    if (x[30:0] == 31'h0) return 0;
    e   = int'(x[30:23]) - 127;
    mag = int'({8'd0, 1'b1, x[22:0]}) >>> (23 - e);
    return x[31] ? -mag : mag;
  endfunction

  // Environment add/sub unit: exact for the integer-valued operands used here.
  always_comb begin
    if (au_a[30:23] == 8'hFF || au_b[30:23] == 8'hFF) begin
      au_result    = FP_EXC_PATTERN;
      au_exception = 1'b1;
    end else begin
      au_exception = 1'b0;
      au_result    = au_sign ? int_to_sp(sp_to_int(au_a) - sp_to_int(au_b))
                             : int_to_sp(sp_to_int(au_a) + sp_to_int(au_b));
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one beat, wait (bounded) for acceptance, check the unit operands
  // seen at acceptance and whether out_valid rises the next cycle.
  task automatic send_beat(input logic [31:0] d, input logic s, input logic l,
                           input logic [31:0] exp_acc);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = s;
    in_last  = l;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_timeout: got in_ready 0 expected 1");
      in_valid = 1'b0;
      return;
    end
    check("au_a", au_a, exp_acc);
    check("au_b", au_b, d);
    check("au_sign", 32'(au_sign), 32'(s));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("out_valid_after_beat", 32'(out_valid), 32'(l));
  endtask

  // Wait for the sum, hold off for 'delay' cycles, then take it.
  task automatic collect(input logic [31:0] exp_sum, input logic exp_exc,
                         input int exp_cnt, input int delay);
    int waited;
    waited = 0;
    while (!out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    for (int i = 0; i < delay; i++) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sum", out_sum, exp_sum);
      @(negedge clk);
    end
    check("out_valid", 32'(out_valid), 32'd1);
    check("out_sum", out_sum, exp_sum);
    check("out_exception", 32'(out_exception), 32'(exp_exc));
    check("out_count", 32'(out_count), 32'(exp_cnt));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("cleared_valid", 32'(out_valid), 32'd0);
    check("cleared_acc", au_a, 32'h0);
    check("ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string            name;
    int               n;
    logic [3:0][31:0] data;
    logic [3:0]       sub;
    logic [31:0]      exp_sum;
    logic             exp_exc;
    int               exp_cnt;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int          sum;
    int          v;
    int          n;
    logic        exc;
    logic        s;
    logic [31:0] d;
    logic [31:0] exp_acc;

    vecs[0] = '{"add",    2, {32'h0, 32'h0, 32'h40000000, 32'h3F800000}, 4'b0000, 32'h40400000, 1'b0, 2};
    vecs[1] = '{"sub",    2, {32'h0, 32'h0, 32'h3F800000, 32'h40400000}, 4'b0010, 32'h40000000, 1'b0, 2};
    vecs[2] = '{"exc",    2, {32'h0, 32'h0, 32'h7F800000, 32'h3F800000}, 4'b0000, 32'hFFFFFFFF, 1'b1, 2};
    vecs[3] = '{"single", 1, {32'h0, 32'h0, 32'h0,        32'h40A00000}, 4'b0000, 32'h40A00000, 1'b0, 1};
    vecs[4] = '{"to_zero",3, {32'h0, 32'h3F800000, 32'h40400000, 32'h40000000}, 4'b0101, 32'h0, 1'b0, 3};

    // ---- reset state ----
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sub = 1'b0; in_last = 1'b0;
    out_ready = 1'b0;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", out_sum, 32'h0);
    check("rst_out_count", 32'(out_count), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);
    @(negedge clk);

    // ---- table-driven directed sums ----
    for (int k = 0; k < 5; k++) begin
      sum = 0;
      exc = 1'b0;
      for (int i = 0; i < vecs[k].n; i++) begin
        exp_acc = exc ? FP_EXC_PATTERN : int_to_sp(sum);
        send_beat(vecs[k].data[i], vecs[k].sub[i], (i == vecs[k].n - 1), exp_acc);
        if (vecs[k].data[i][30:23] == 8'hFF) exc = 1'b1;
        else sum += vecs[k].sub[i] ? -sp_to_int(vecs[k].data[i]) : sp_to_int(vecs[k].data[i]);
      end
      collect(vecs[k].exp_sum, vecs[k].exp_exc, vecs[k].exp_cnt, k % 2);
    end

    // ---- back-pressure with in_valid held in DONE ----
    send_beat(32'h3F800000, 1'b0, 1'b0, 32'h0);
    send_beat(32'h40000000, 1'b0, 1'b1, 32'h3F800000);
    in_valid = 1'b1; in_data = 32'h41200000; in_sub = 1'b0; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_sum", out_sum, 32'h40400000);
      check("bp_count", 32'(out_count), 32'd2);
      check("bp_exc", 32'(out_exception), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("hs_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_valid", 32'(out_valid), 32'd0);
    check("post_hs_ready", 32'(in_ready), 32'd1);
    check("post_hs_acc", au_a, 32'h0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("next_beat_valid", 32'(out_valid), 32'd1);
    collect(32'h41200000, 1'b0, 1, 0);

    // ---- count saturation ----
    for (int i = 0; i < CNT_SAT + 2; i++)
      send_beat(32'h3F800000, 1'b0, (i == CNT_SAT + 1), int_to_sp(i));
    collect(int_to_sp(CNT_SAT + 2), 1'b0, CNT_SAT, 0);

    // ---- reset mid-sum ----
    send_beat(32'h40000000, 1'b0, 1'b0, 32'h0);
    send_beat(32'h40400000, 1'b0, 1'b0, 32'h40000000);
    check("pre_rst_count", 32'(out_count), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum", out_sum, 32'h0);
    check("mid_rst_count", 32'(out_count), 32'd0);
    check("mid_rst_exc", 32'(out_exception), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    send_beat(32'h3F800000, 1'b0, 1'b1, 32'h0);
    collect(32'h3F800000, 1'b0, 1, 0);

    // ---- random sums against an integer reference ----
    for (int t = 0; t < 25; t++) begin
      n   = $urandom_range(1, 20);
      sum = 0;
      exc = 1'b0;
      for (int i = 0; i < n; i++) begin
        v = $urandom_range(0, 15);
        s = 1'($urandom_range(0, 1));
        d = ($urandom_range(0, 29) == 0) ? 32'h7F800000 : int_to_sp(v);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        exp_acc = exc ? FP_EXC_PATTERN : int_to_sp(sum);
        send_beat(d, s, (i == n - 1), exp_acc);
        if (d[30:23] == 8'hFF) exc = 1'b1;
        else sum += s ? -v : v;
      end
      collect(exc ? FP_EXC_PATTERN : int_to_sp(sum), exc,
              (n > CNT_SAT) ? CNT_SAT : n, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
